// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock,
// unsigned or two's-complement, with optional early exit on first difference.
module seq_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             rec_gt, rec_lt;
  logic [DIGIT-1:0] da, db;
  logic             dig_gt, dig_lt, last, finish;
  logic             fin_gt, fin_lt;

  assign da     = sa[WIDTH-1 -: DIGIT];
  assign db     = sb[WIDTH-1 -: DIGIT];
  assign dig_gt = (da > db);
  assign dig_lt = (da < db);
  assign last   = (cnt == LAST);
  assign finish = ((EARLY_EXIT != 0) && (dig_gt || dig_lt)) || last;
  // The first differing digit decides; later digits never override it.
  assign fin_gt = rec_gt | (~rec_lt & dig_gt);
  assign fin_lt = rec_lt | (~rec_gt & dig_lt);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers, digit counter, recorded and latched result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      rec_gt <= 1'b0;
      rec_lt <= 1'b0;
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= signed_mode ? (a ^ MSB) : a;
            sb     <= signed_mode ? (b ^ MSB) : b;
            cnt    <= '0;
            rec_gt <= 1'b0;
            rec_lt <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
          end
        end
        RUN: begin
          if (finish) begin
            gt <= fin_gt;
            lt <= fin_lt;
            eq <= ~fin_gt & ~fin_lt;
          end else begin
            sa     <= sa << DIGIT;
            sb     <= sb << DIGIT;
            cnt    <= cnt + 1'b1;
            rec_gt <= fin_gt;
            rec_lt <= fin_lt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: W8/D2 early-exit, W8/D2 fixed latency, W4/D4.
module tb_seq_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] start = '0;
  logic [2:0] busy, done, gt, eq, lt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]));

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]));

  seq_mag_comparator #(.WIDTH(4), .DIGIT(4), .EARLY_EXIT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .signed_mode(signed_mode),
    .a(a[3:0]), .b(b[3:0]), .busy(busy[2]), .done(done[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res(input int w);
    return {gt[w], eq[w], lt[w]};
  endfunction

  // Start one compare on instance w and follow it to the done pulse.
  // exp_r is {gt,eq,lt}; exp_m is the number of digits examined.
  task automatic do_cmp(input int w, input string tag, input logic [7:0] va,
                        input logic [7:0] vb, input logic sm,
                        input logic [2:0] exp_r, input int exp_m);
    int  m = -1;
    int  busy_cnt = 0;
    @(negedge clk);
    a = va; b = vb; signed_mode = sm; start[w] = 1'b1;
    @(negedge clk);                         // just after edge 0
    start = '0;
    a = ~va; b = ~vb; signed_mode = ~sm;    // post-capture changes must not matter
    for (int k = 0; k <= 20; k++) begin
      if (done[w]) begin m = k; break; end
      if (busy[w]) busy_cnt++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, (m >= 0), 1);
    if (m >= 0) begin
      check({tag, " latency"}, m, exp_m);
      check({tag, " busy_cycles"}, busy_cnt, exp_m);
      check({tag, " result"}, res(w), exp_r);
      check({tag, " busy_at_done"}, busy[w], 0);
      @(negedge clk);
      check({tag, " done_pulse_end"}, done[w], 0);
      check({tag, " result_hold"}, res(w), exp_r);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs_ee1", {busy[0], done[0], res(0)}, 0);
    check("reset_outs_ee0", {busy[1], done[1], res(1)}, 0);
    check("reset_outs_w4",  {busy[2], done[2], res(2)}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_result", res(0), 0);

    // 1) equal operands run all digits
    do_cmp(0, "eq_a5", 8'hA5, 8'hA5, 1'b0, 3'b010, 4);
    // 2) MSB digit decides immediately
    do_cmp(0, "u_80_7f", 8'h80, 8'h7F, 1'b0, 3'b100, 1);
    do_cmp(0, "s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b001, 1);
    // 3) difference only in the last digit
    do_cmp(0, "s_ff_fe", 8'hFF, 8'hFE, 1'b1, 3'b100, 4);
    do_cmp(0, "u_00_01", 8'h00, 8'h01, 1'b0, 3'b001, 4);

    // 4) start while busy and while done is ignored, not queued
    @(negedge clk);
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start[0] = 1'b1;
    @(negedge clk);                         // after edge 0
    check("ign_busy_e0", busy[0], 1);
    a = 8'h30; b = 8'h01;                   // start kept high across edge 1 (RUN)
    @(negedge clk);                         // after edge 1
    start = '0;
    check("ign_busy_e1", {busy[0], done[0]}, 2'b10);
    @(negedge clk);                         // after edge 2
    check("ign_done", done[0], 1);
    check("ign_result", res(0), 3'b001);
    start[0] = 1'b1;                        // start seen only in DONE at edge 3
    @(negedge clk);                         // after edge 3
    start = '0;
    check("ign_no_queue", {busy[0], done[0]}, 2'b00);
    @(negedge clk);
    check("ign_still_idle", {busy[0], done[0], res(0)}, 5'b00001);
    do_cmp(0, "after_ign", 8'h30, 8'h01, 1'b0, 3'b100, 2);

    // 5) asynchronous reset mid-RUN aborts without a result
    @(negedge clk);
    a = 8'h00; b = 8'h01; signed_mode = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start = '0;
    @(negedge clk);                         // after edge 1, still RUN
    check("pre_rst_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {busy[0], done[0], res(0)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_done", {busy[0], done[0]}, 0);
    end
    do_cmp(0, "post_rst", 8'h05, 8'h03, 1'b0, 3'b100, 3);

    // 6) fixed latency and single-digit configurations
    do_cmp(1, "ee0_80_00", 8'h80, 8'h00, 1'b0, 3'b100, 4);
    do_cmp(1, "ee0_s_01_ff", 8'h01, 8'hFF, 1'b1, 3'b100, 4);
    do_cmp(1, "ee0_eq", 8'h3C, 8'h3C, 1'b0, 3'b010, 4);
    do_cmp(2, "w4_eq", 8'h03, 8'h03, 1'b0, 3'b010, 1);
    do_cmp(2, "w4_s_lt", 8'h08, 8'h07, 1'b1, 3'b001, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
